// File: rtl/ofmap_writer.sv
// Packs a valid/ready stream of PE output elements into SRAM words and writes them from a base address.
// Latency: write strobe one cycle after the handshake that fills a word or takes the last element; done one cycle after the last strobe.
// Backpressure: o_ready drops during the write and done cycles; a gap in i_valid simply stalls packing.
module ofmap_writer #(
    parameter int DATA_WIDTH      = 8,
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_reg_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [COUNT_WIDTH-1:0]     i_count,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_ready,
    output logic                       o_sram_write_en,
    output logic [ADDR_WIDTH-1:0]      o_sram_write_addr,
    output logic [SRAM_DATA_WIDTH-1:0] o_sram_data_out,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int PACK   = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      base_q, base_d;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;
    logic [COUNT_WIDTH-1:0]     acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]      word_q, word_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [SRAM_DATA_WIDTH-1:0] pack_q, pack_d;

    // Clear acts exactly like reset: any partial word is dropped without a write.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_reg_clear) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        count_d           = count_q;
        acc_d             = acc_q;
        word_d            = word_q;
        lane_d            = lane_q;
        pack_d            = pack_q;
        o_ready           = 1'b0;
        o_sram_write_en   = 1'b0;
        o_sram_write_addr = '0;
        o_sram_data_out   = '0;
        o_done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    count_d = i_count;
                    acc_d   = '0;
                    word_d  = '0;
                    lane_d  = '0;
                    pack_d  = '0;
                    state_d = (i_count == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    for (int l = 0; l < PACK; l++) begin
                        if (lane_q == LANE_W'(l)) begin
                            pack_d[l*DATA_WIDTH +: DATA_WIDTH] = i_data;
                        end
                    end
                    acc_d  = acc_q + COUNT_WIDTH'(1);
                    lane_d = lane_q + LANE_W'(1);
                    if ((lane_q == LANE_W'(PACK - 1)) || (acc_d == count_q)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                o_sram_write_en   = 1'b1;
                o_sram_write_addr = base_q + word_q;
                o_sram_data_out   = pack_q;
                word_d            = word_q + ADDR_WIDTH'(1);
                lane_d            = '0;
                pack_d            = '0;
                state_d           = (acc_q == count_q) ? S_DONE : S_PACK;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ofmap_writer.sv
// Randomized and directed bench for ofmap_writer against a word-list reference model.
module tb_ofmap_writer;
    localparam int DW = 8;
    localparam int SW = 64;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int PK = SW / DW;

    logic          i_clk = 1'b0;
    logic          i_rst, i_reg_clear, i_start, i_valid;
    logic [AW-1:0] i_base_addr;
    logic [CW-1:0] i_count;
    logic [DW-1:0] i_data;
    logic          o_ready, o_sram_write_en, o_busy, o_done;
    logic [AW-1:0] o_sram_write_addr;
    logic [SW-1:0] o_sram_data_out;

    always #5 i_clk = ~i_clk;

    ofmap_writer #(.DATA_WIDTH(DW), .SRAM_DATA_WIDTH(SW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_count(i_count), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_sram_write_en(o_sram_write_en), .o_sram_write_addr(o_sram_write_addr),
        .o_sram_data_out(o_sram_data_out), .o_busy(o_busy), .o_done(o_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    logic [AW-1:0] wa_q[$];
    logic [SW-1:0] wd_q[$];
    int            wc_q[$];
    int            exp_cyc[$];
    logic [DW-1:0] elems[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            ready_hi = 0;

    // Observes the write port mid-cycle and logs every strobe and done pulse.
    always @(negedge i_clk) begin
        if (o_sram_write_en) begin
            wa_q.push_back(o_sram_write_addr);
            wd_q.push_back(o_sram_data_out);
            wc_q.push_back(cyc);
        end else begin
            chk("zero_when_no_strobe", 64'((|o_sram_write_addr) || (|o_sram_data_out)), 64'd0);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_ready) ready_hi++;
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        exp_cyc.delete(); elems.delete();
        done_cnt = 0; ready_hi = 0;
    endtask

    // mode 0: valid every cycle, 1: 1,0,1,0..., 2: random gaps. first<0 means random data.
    task automatic run_map(input logic [AW-1:0] base, input int count, input int mode,
                           input bit stray, input int first);
        int idx = 0;
        int guard = 0;
        int start_cyc;
        int nw;
        bit tog = 1'b1;
        bit v;
        logic [SW-1:0] ed;
        logic [AW-1:0] ea;
        clear_log();
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = base; i_count = CW'(count); start_cyc = cyc;
        @(negedge i_clk);
        i_start = 1'b0; i_base_addr = AW'($urandom); i_count = CW'($urandom);
        while (idx < count && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_valid = v;
            i_data  = (v && first >= 0) ? DW'(first + idx) : DW'($urandom);
            if (stray && idx == 3) begin
                i_start = 1'b1; i_base_addr = base + 8'h20; i_count = CW'(count + 5);
            end else begin
                i_start = 1'b0;
            end
            #1;
            if (v && o_ready) begin
                elems.push_back(i_data);
                idx++;
                if (idx % PK == 0 || idx == count) exp_cyc.push_back(cyc + 1);
            end
            @(negedge i_clk);
            guard++;
        end
        i_valid = 1'b0; i_start = 1'b0;
        if (guard >= 2000) chk("feed_timeout", 64'd0, 64'd1);
        guard = 0;
        #2;
        while (done_cnt == 0 && guard < 50) begin
            @(negedge i_clk); #2; guard++;
        end
        repeat (3) @(negedge i_clk);
        #2;
        nw = (count + PK - 1) / PK;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("n_writes", 64'(wa_q.size()), 64'(nw));
        for (int w = 0; w < nw && w < wa_q.size(); w++) begin
            ea = base + AW'(w);
            ed = '0;
            for (int l = 0; l < PK; l++)
                if (w * PK + l < elems.size()) ed = ed | (SW'(elems[w * PK + l]) << (l * DW));
            chk("wr_addr", 64'(wa_q[w]), 64'(ea));
            chk("wr_data", wd_q[w], ed);
            if (w < exp_cyc.size()) chk("wr_latency", 64'(wc_q[w]), 64'(exp_cyc[w]));
        end
        if (count > 0) begin
            if (wc_q.size() > 0) chk("done_latency", 64'(done_cyc), 64'(wc_q[wc_q.size() - 1] + 1));
        end else begin
            chk("zero_done_window", 64'((done_cyc == start_cyc + 1) || (done_cyc == start_cyc + 2)), 64'd1);
            chk("zero_no_ready", 64'(ready_hi), 64'd0);
        end
        chk("idle_after_map", 64'(o_busy), 64'd0);
    endtask

    task automatic run_abort(input bit use_clear);
        int idx = 0;
        int guard = 0;
        clear_log();
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = 8'h50; i_count = 16'd9;
        @(negedge i_clk);
        i_start = 1'b0;
        while (idx < 5 && guard < 100) begin
            i_valid = 1'b1; i_data = DW'(idx + 1);
            #1;
            if (o_ready) idx++;
            @(negedge i_clk);
            guard++;
        end
        i_valid = 1'b0;
        if (use_clear) i_reg_clear = 1'b1; else i_rst = 1'b1;
        @(negedge i_clk);
        i_reg_clear = 1'b0; i_rst = 1'b0;
        repeat (15) @(negedge i_clk);
        #2;
        chk(use_clear ? "clear_no_write" : "rst_no_write", 64'(wa_q.size()), 64'd0);
        chk(use_clear ? "clear_no_done" : "rst_no_done", 64'(done_cnt), 64'd0);
        chk(use_clear ? "clear_idle" : "rst_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int cnt;
        i_rst = 1'b1; i_reg_clear = 1'b0; i_start = 1'b0; i_valid = 1'b0;
        i_base_addr = '0; i_count = '0; i_data = '0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_wr_en", 64'(o_sram_write_en), 64'd0);
        i_rst = 1'b0;

        run_map(8'h10, 9, 0, 1'b0, 1);
        run_map(8'h44, 0, 0, 1'b0, -1);
        run_map(8'hFF, 16, 0, 1'b0, 16'h10);
        run_map(8'h05, 8, 1, 1'b0, 1);
        run_map(8'h20, 9, 0, 1'b1, 1);
        run_abort(1'b0);
        run_map(8'h30, 8, 0, 1'b0, 1);
        run_abort(1'b1);
        run_map(8'h30, 8, 2, 1'b0, 1);

        for (int k = 0; k < 20; k++) begin
            cnt = $urandom_range(0, 40);
            run_map(AW'($urandom), cnt, $urandom_range(0, 2), bit'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
